// File: rtl/char_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : char_stream_arbiter
// Purpose  : Round-robin sharing of one character recognizer between several
//            character sources, with separator flushing between messages and
//            per-source attribution of recognizer matches.
// Revision : 1.0
// ============================================================================
module char_stream_arbiter #(
  parameter int         NUM_SRC      = 4,
  parameter logic [7:0] SEP_CHAR     = 8'h20,
  parameter int         MAX_LEN      = 16,
  parameter int         FLUSH_CYCLES = 2,
  parameter int         SRC_W        = $clog2(NUM_SRC)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_char,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic [7:0]           rec_char,
  input  logic                 rec_match,
  output logic                 match_valid,
  output logic [SRC_W-1:0]     match_src,
  output logic                 overflow_err,
  output logic                 busy
);

  localparam int c_LEN_W = $clog2(MAX_LEN + 1);
  localparam int c_FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [c_LEN_W-1:0] c_MAX_LEN  = c_LEN_W'(MAX_LEN);
  localparam logic [c_FC_W-1:0]  c_FC_LAST  = c_FC_W'(FLUSH_CYCLES - 1);
  localparam logic [SRC_W-1:0]   c_RR_RESET = SRC_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t               r_state;
  logic [SRC_W-1:0]     r_owner;
  logic [SRC_W-1:0]     r_rr_ptr;
  logic [c_LEN_W-1:0]   r_len;
  logic [c_FC_W-1:0]    r_flush_cnt;
  logic [7:0]           r_rec_char;
  logic                 r_match_valid;
  logic [SRC_W-1:0]     r_match_src;
  logic                 r_overflow;

  state_t               w_state_nxt;
  logic [SRC_W-1:0]     w_owner_nxt;
  logic [SRC_W-1:0]     w_rr_nxt;
  logic [c_LEN_W-1:0]   w_len_nxt;
  logic [c_FC_W-1:0]    w_fc_nxt;
  logic [7:0]           w_rec_nxt;
  logic                 w_mv_nxt;
  logic [SRC_W-1:0]     w_ms_nxt;
  logic                 w_ovf_nxt;

  logic                 w_pick_found;
  logic [SRC_W-1:0]     w_pick;
  logic [SRC_W-1:0]     w_cand;
  logic [7:0]           w_owner_char;

  function automatic logic [SRC_W-1:0] rr_index(input logic [SRC_W-1:0] base, input int k);
    int sum;
    sum = (int'(base) + k) % NUM_SRC;
    return SRC_W'(sum);
  endfunction

  // Scan downward so the candidate closest after rr_ptr is the last one written.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick       = '0;
    w_cand       = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      w_cand = rr_index(r_rr_ptr, k);
      if (src_valid[w_cand]) begin
        w_pick_found = 1'b1;
        w_pick       = w_cand;
      end
    end
  end

  assign w_owner_char = src_char[{r_owner, 3'b000} +: 8];

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    w_len_nxt   = r_len;
    w_fc_nxt    = r_flush_cnt;
    w_rec_nxt   = SEP_CHAR;
    w_ovf_nxt   = 1'b0;
    w_mv_nxt    = rec_match && (r_state != S_IDLE);
    w_ms_nxt    = w_mv_nxt ? r_owner : r_match_src;
    src_ready   = '0;

    case (r_state)
      S_IDLE: begin
        if (w_pick_found) begin
          w_owner_nxt = w_pick;
          w_rr_nxt    = w_pick;
          w_len_nxt   = '0;
          w_state_nxt = S_STREAM;
        end
      end

      S_STREAM: begin
        src_ready[r_owner] = 1'b1;
        // A gap leaves the separator on rec_char but keeps the message open.
        if (src_valid[r_owner]) begin
          w_rec_nxt = w_owner_char;
          w_len_nxt = r_len + c_LEN_W'(1);
          if (src_last[r_owner]) begin
            w_state_nxt = S_FLUSH;
            w_fc_nxt    = '0;
          end else if (w_len_nxt == c_MAX_LEN) begin
            w_state_nxt = S_FLUSH;
            w_fc_nxt    = '0;
            w_ovf_nxt   = 1'b1;
          end
        end
      end

      S_FLUSH: begin
        if (r_flush_cnt == c_FC_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_fc_nxt = r_flush_cnt + c_FC_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_owner       <= '0;
      r_rr_ptr      <= c_RR_RESET;
      r_len         <= '0;
      r_flush_cnt   <= '0;
      r_rec_char    <= SEP_CHAR;
      r_match_valid <= 1'b0;
      r_match_src   <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_owner       <= w_owner_nxt;
      r_rr_ptr      <= w_rr_nxt;
      r_len         <= w_len_nxt;
      r_flush_cnt   <= w_fc_nxt;
      r_rec_char    <= w_rec_nxt;
      r_match_valid <= w_mv_nxt;
      r_match_src   <= w_ms_nxt;
      r_overflow    <= w_ovf_nxt;
    end
  end

  assign rec_char     = r_rec_char;
  assign match_valid  = r_match_valid;
  assign match_src    = r_match_src;
  assign overflow_err = r_overflow;
  assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_char_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_char_stream_arbiter
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a message-level reference model.
// Revision : 1.0
// ============================================================================
module tb_char_stream_arbiter;

  localparam int         N    = 4;
  localparam logic [7:0] SEP  = 8'h20;
  localparam int         MAXL = 16;
  localparam int         FLC  = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   src_valid;
  logic [8*N-1:0] src_char;
  logic [N-1:0]   src_last;
  logic [N-1:0]   src_ready;
  logic [7:0]     rec_char;
  logic           rec_match;
  logic           match_valid;
  logic [1:0]     match_src;
  logic           overflow_err;
  logic           busy;

  int n_pass  = 0;
  int n_total = 0;

  char_stream_arbiter #(
    .NUM_SRC(N), .SEP_CHAR(SEP), .MAX_LEN(MAXL), .FLUSH_CYCLES(FLC), .SRC_W(2)
  ) dut (
    .clock(clock), .reset(reset),
    .src_valid(src_valid), .src_char(src_char), .src_last(src_last),
    .src_ready(src_ready), .rec_char(rec_char), .rec_match(rec_match),
    .match_valid(match_valid), .match_src(match_src),
    .overflow_err(overflow_err), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] valid;
    logic [7:0] ch;
    logic [3:0] last;
    logic       match;
    logic [3:0] e_ready;
    logic [7:0] e_rec;
    logic       e_mv;
    logic [1:0] e_ms;
    logic       e_ovf;
    logic       e_busy;
  } vec_t;

  vec_t tbl [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [7:0] ch);
    src_valid = v;
    src_last  = l;
    src_char  = {N{ch}};
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    rec_match = 1'b0;
    drive(4'b0000, 4'b0000, SEP);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference model state (message level)
  int         m_phase;      // 0 idle, 1 streaming, 2 flushing
  int         m_owner;
  int         m_last_served;
  int         m_len;
  int         m_flush_left;
  logic [7:0] e_rec;
  logic       e_mv;
  logic [1:0] e_ms;
  logic       e_ovf;
  logic       e_busy;

  int         rem [N];
  logic [7:0] cur [N];
  bit         rv  [N];
  bit         rl  [N];

  initial begin
    // ---- vector table: WINDOW on source 0, IDLE match, gapped OPEN on source 1
    tbl[0]  = '{4'b0001, "W", 4'b0000, 1'b0, 4'b0000, SEP, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[1]  = '{4'b0001, "W", 4'b0000, 1'b0, 4'b0001, "W", 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[2]  = '{4'b0001, "I", 4'b0000, 1'b0, 4'b0001, "I", 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[3]  = '{4'b0001, "N", 4'b0000, 1'b0, 4'b0001, "N", 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[4]  = '{4'b0001, "D", 4'b0000, 1'b0, 4'b0001, "D", 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[5]  = '{4'b0001, "O", 4'b0000, 1'b0, 4'b0001, "O", 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[6]  = '{4'b0001, "W", 4'b0001, 1'b0, 4'b0001, "W", 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[7]  = '{4'b0000, "W", 4'b0000, 1'b1, 4'b0000, SEP, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[8]  = '{4'b0000, "W", 4'b0000, 1'b0, 4'b0000, SEP, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[9]  = '{4'b0000, "W", 4'b0000, 1'b1, 4'b0000, SEP, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[10] = '{4'b0010, "O", 4'b0000, 1'b0, 4'b0000, SEP, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[11] = '{4'b0010, "O", 4'b0000, 1'b0, 4'b0010, "O", 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[12] = '{4'b0010, "P", 4'b0000, 1'b0, 4'b0010, "P", 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[13] = '{4'b0010, "E", 4'b0000, 1'b0, 4'b0010, "E", 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[14] = '{4'b0001, "N", 4'b0000, 1'b0, 4'b0010, SEP, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[15] = '{4'b0011, "N", 4'b0010, 1'b0, 4'b0010, "N", 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[16] = '{4'b0001, "N", 4'b0000, 1'b0, 4'b0000, SEP, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[17] = '{4'b0001, "N", 4'b0000, 1'b0, 4'b0000, SEP, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[18] = '{4'b0001, "A", 4'b0000, 1'b0, 4'b0000, SEP, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[19] = '{4'b0001, "A", 4'b0001, 1'b0, 4'b0001, "A", 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[20] = '{4'b0000, "A", 4'b0000, 1'b0, 4'b0000, SEP, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[21] = '{4'b0000, "A", 4'b0000, 1'b0, 4'b0000, SEP, 1'b0, 2'd0, 1'b0, 1'b0};

    // ---- reset values (sampled while reset is still asserted)
    reset     = 1'b1;
    rec_match = 1'b0;
    drive(4'b0000, 4'b0000, SEP);
    tick();
    tick();
    check("rst_rec_char", 32'(rec_char), 32'(SEP));
    check("rst_ready", 32'(src_ready), 32'(0));
    check("rst_match_valid", 32'(match_valid), 32'(0));
    check("rst_match_src", 32'(match_src), 32'(0));
    check("rst_overflow", 32'(overflow_err), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].valid, tbl[i].last, tbl[i].ch);
      rec_match = tbl[i].match;
      check($sformatf("tbl%0d_ready", i), 32'(src_ready), 32'(tbl[i].e_ready));
      tick();
      check($sformatf("tbl%0d_rec_char", i), 32'(rec_char), 32'(tbl[i].e_rec));
      check($sformatf("tbl%0d_match_valid", i), 32'(match_valid), 32'(tbl[i].e_mv));
      check($sformatf("tbl%0d_match_src", i), 32'(match_src), 32'(tbl[i].e_ms));
      check($sformatf("tbl%0d_overflow", i), 32'(overflow_err), 32'(tbl[i].e_ovf));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
    end

    // ---- round-robin: one-character messages
    do_reset();
    drive(4'b0101, 4'b0101, 8'h61);
    tick();
    check("rr_grant_0_first", 32'(src_ready), 32'(4'b0001));
    tick();
    check("rr_char_src0", 32'(rec_char), 32'(8'h61));
    drive(4'b0100, 4'b0100, 8'h62);
    tick(); tick(); tick();
    check("rr_grant_2", 32'(src_ready), 32'(4'b0100));
    drive(4'b0101, 4'b0101, 8'h63);
    tick();
    check("rr_char_src2", 32'(rec_char), 32'(8'h63));
    tick(); tick(); tick();
    check("rr_grant_0_again", 32'(src_ready), 32'(4'b0001));
    tick();
    drive(4'b1010, 4'b1010, 8'h64);
    tick(); tick(); tick();
    check("rr_grant_1_over_3", 32'(src_ready), 32'(4'b0010));
    tick();
    check("rr_char_src1", 32'(rec_char), 32'(8'h64));
    tick(); tick(); tick();
    check("rr_grant_3", 32'(src_ready), 32'(4'b1000));
    tick();
    drive(4'b0000, 4'b0000, SEP);
    tick(); tick(); tick();

    // ---- overflow: source 3, 17 characters, never last
    drive(4'b1000, 4'b0000, 8'h61);
    tick();
    check("ovf_grant", 32'(src_ready), 32'(4'b1000));
    for (int i = 0; i < 16; i++) begin
      logic [7:0] c;
      c = 8'(8'h61 + i);
      src_char = {N{c}};
      tick();
      check($sformatf("ovf_char%0d", i), 32'(rec_char), 32'(c));
      check($sformatf("ovf_pulse%0d", i), 32'(overflow_err), 32'(i == 15));
    end
    src_char = {N{8'h71}};
    for (int j = 0; j < 3; j++) begin
      check($sformatf("ovf_noaccept%0d", j), 32'(src_ready), 32'(0));
      tick();
      check($sformatf("ovf_gapchar%0d", j), 32'(rec_char), 32'(SEP));
      check($sformatf("ovf_nopulse%0d", j), 32'(overflow_err), 32'(0));
    end
    check("ovf_regrant", 32'(src_ready), 32'(4'b1000));
    src_last = 4'b1000;
    tick();
    check("ovf_char17", 32'(rec_char), 32'(8'h71));
    drive(4'b0000, 4'b0000, SEP);
    tick(); tick(); tick();

    // ---- attribution window
    rec_match = 1'b1;
    tick();
    check("attr_idle_ignored", 32'(match_valid), 32'(0));
    rec_match = 1'b0;
    drive(4'b0100, 4'b0000, 8'h78);
    tick();
    check("attr_grant2", 32'(src_ready), 32'(4'b0100));
    tick();
    drive(4'b0100, 4'b0100, 8'h79);
    tick();
    drive(4'b0000, 4'b0000, SEP);
    tick();
    check("attr_flush1_none", 32'(match_valid), 32'(0));
    rec_match = 1'b1;
    tick();
    check("attr_flush2_valid", 32'(match_valid), 32'(1));
    check("attr_flush2_src", 32'(match_src), 32'(2));
    rec_match = 1'b0;
    tick();
    check("attr_pulse_ends", 32'(match_valid), 32'(0));
    check("attr_src_holds", 32'(match_src), 32'(2));

    // ---- reset in the middle of source 1's message
    drive(4'b0010, 4'b0000, 8'h31);
    tick();
    check("rst_mid_grant1", 32'(src_ready), 32'(4'b0010));
    tick();
    src_char = {N{8'h32}};
    tick();
    drive(4'b0011, 4'b0000, 8'h33);
    rec_match = 1'b1;
    reset     = 1'b1;
    tick();
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_rec_char", 32'(rec_char), 32'(SEP));
    check("rst_mid_match_valid", 32'(match_valid), 32'(0));
    check("rst_mid_ready", 32'(src_ready), 32'(0));
    reset     = 1'b0;
    rec_match = 1'b0;
    tick();
    check("rst_mid_grant0", 32'(src_ready), 32'(4'b0001));

    // ---- randomized traffic against the reference model
    do_reset();
    m_phase = 0; m_owner = 0; m_last_served = N - 1; m_len = 0; m_flush_left = 0;
    e_ms = 2'd0;
    for (int s = 0; s < N; s++) begin
      rem[s] = 0;
      cur[s] = 8'h00;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic rs;
      logic rm;
      logic [3:0] e_ready;
      bit   accepted;
      for (int s = 0; s < N; s++) begin
        if (rem[s] == 0 && $urandom_range(0, 3) == 0) begin
          rem[s] = int'($urandom_range(1, 20));
          cur[s] = 8'($urandom);
        end
        rv[s] = (rem[s] > 0) && ($urandom_range(0, 9) < 8);
        rl[s] = (rem[s] == 1);
        src_valid[s] = rv[s];
        src_last[s]  = rl[s];
        src_char[8*s +: 8] = rv[s] ? cur[s] : 8'($urandom);
      end
      rm = ($urandom_range(0, 6) == 0);
      rs = ($urandom_range(0, 199) == 0);
      rec_match = rm;
      reset     = rs;

      e_ready = (m_phase == 1) ? 4'(1 << m_owner) : 4'b0000;
      check("rnd_ready", 32'(src_ready), 32'(e_ready));

      accepted = 1'b0;
      e_rec    = SEP;
      e_ovf    = 1'b0;
      if (rs) begin
        m_phase = 0; m_owner = 0; m_last_served = N - 1; m_len = 0;
        e_mv = 1'b0;
        e_ms = 2'd0;
      end else begin
        e_mv = rm && (m_phase != 0);
        if (e_mv) e_ms = 2'(m_owner);
        if (m_phase == 0) begin
          for (int k = 1; k <= N; k++) begin
            int s;
            s = (m_last_served + k) % N;
            if (rv[s] && m_phase == 0) begin
              m_owner = s; m_last_served = s; m_len = 0; m_phase = 1;
            end
          end
        end else if (m_phase == 1) begin
          if (rv[m_owner]) begin
            accepted = 1'b1;
            e_rec    = cur[m_owner];
            m_len++;
            if (rl[m_owner]) begin
              m_phase = 2; m_flush_left = FLC;
            end else if (m_len == MAXL) begin
              m_phase = 2; m_flush_left = FLC; e_ovf = 1'b1;
            end
          end
        end else begin
          m_flush_left--;
          if (m_flush_left == 0) m_phase = 0;
        end
      end
      e_busy = (m_phase != 0);

      tick();
      check("rnd_rec_char", 32'(rec_char), 32'(e_rec));
      check("rnd_match_valid", 32'(match_valid), 32'(e_mv));
      check("rnd_match_src", 32'(match_src), 32'(e_ms));
      check("rnd_overflow", 32'(overflow_err), 32'(e_ovf));
      check("rnd_busy", 32'(busy), 32'(e_busy));

      if (accepted) begin
        rem[m_owner]--;
        cur[m_owner] = 8'($urandom);
      end
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
